// File: rtl/multi_mode_modulator_if.sv
// Host-side bundle of the modulator: message/config inputs and the busy/done/sample outputs.
// Handshake: send is sampled only while idle; busy marks an active frame; done pulses one cycle as the frame ends.
interface multi_mode_modulator_if #(
    parameter int MSG_W  = 8,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 9,
    parameter int BAUD_W = 12
);
    logic              send;
    logic [1:0]        mode;
    logic [MSG_W-1:0]  message;
    logic [DIV_W-1:0]  div_hi;
    logic [DIV_W-1:0]  div_lo;
    logic [BAUD_W-1:0] baud_div;
    logic              busy;
    logic              done;
    logic              bit_out;
    logic [DATA_W-1:0] data_out;
    logic              dbg_state;

    modport master (
        output send, mode, message, div_hi, div_lo, baud_div,
        input  busy, done, bit_out, data_out, dbg_state
    );

    modport slave (
        input  send, mode, message, div_hi, div_lo, baud_div,
        output busy, done, bit_out, data_out, dbg_state
    );
endinterface

// File: rtl/multi_mode_modulator.sv
// ASK/FSK/BPSK serial modulator over a sawtooth carrier, with a send/busy/done handshake.
// Define MOD_PARITY_EN to append an even-parity bit after the message LSB.
module multi_mode_modulator #(
    parameter int MSG_W  = 8,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 9,
    parameter int BAUD_W = 12
) (
    input logic                 clk,
    input logic                 rst,
    multi_mode_modulator_if.slave bus
);
`ifdef MOD_PARITY_EN
    localparam int N = MSG_W + 1;
`else
    localparam int N = MSG_W;
`endif
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_done;
    logic [1:0]        r_mode;
    logic [DIV_W-1:0]  r_div_hi;
    logic [DIV_W-1:0]  r_div_lo;
    logic [BAUD_W-1:0] r_baud_div;
    logic [N-1:0]      r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [DIV_W-1:0]  r_car_cnt;
    logic [DATA_W-1:0] r_phase;

    logic [N-1:0]      w_frame;
    logic              w_cur_bit;
    logic [DIV_W-1:0]  w_div_act;
    logic              w_car_tick;
    logic              w_baud_wrap;
    logic              w_last_bit;
    logic              w_start;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_data;

`ifdef MOD_PARITY_EN
    assign w_frame = {bus.message, ^bus.message};
`else
    assign w_frame = bus.message;
`endif

    assign w_cur_bit   = r_shift[N-1];
    // FSK space bits use div_lo; everything else runs on div_hi.
    assign w_div_act   = (r_mode == 2'b01 && !w_cur_bit) ? r_div_lo : r_div_hi;
    assign w_car_tick  = (r_car_cnt == w_div_act);
    assign w_baud_wrap = (r_baud_cnt == r_baud_div);
    assign w_last_bit  = (r_bit_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.send) begin
                    w_state_nxt = S_SEND;
                    w_start     = 1'b1;
                end
            end
            S_SEND: begin
                if (w_baud_wrap && w_last_bit) begin
                    w_state_nxt = S_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done     <= 1'b0;
            r_mode     <= '0;
            r_div_hi   <= '0;
            r_div_lo   <= '0;
            r_baud_div <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_car_cnt  <= '0;
            r_phase    <= '0;
        end else begin
            r_done <= w_frame_end;
            if (w_start) begin
                r_mode     <= bus.mode;
                r_div_hi   <= bus.div_hi;
                r_div_lo   <= bus.div_lo;
                r_baud_div <= bus.baud_div;
                r_shift    <= w_frame;
                r_bit_cnt  <= '0;
                r_baud_cnt <= '0;
                r_car_cnt  <= '0;
                r_phase    <= '0;
            end else if (r_state == S_SEND && !w_frame_end) begin
                // Phase runs on across bit boundaries; only the divider count restarts.
                if (w_car_tick) r_phase <= r_phase + 1'b1;
                if (w_baud_wrap) begin
                    r_baud_cnt <= '0;
                    r_car_cnt  <= '0;
                    r_shift    <= r_shift << 1;
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                end else begin
                    r_baud_cnt <= r_baud_cnt + 1'b1;
                    r_car_cnt  <= w_car_tick ? '0 : r_car_cnt + 1'b1;
                end
            end else begin
                r_bit_cnt  <= '0;
                r_baud_cnt <= '0;
                r_car_cnt  <= '0;
                r_phase    <= '0;
            end
        end
    end

    always_comb begin
        w_data = MID;
        if (r_state == S_SEND) begin
            case (r_mode)
                2'b00:   w_data = w_cur_bit ? r_phase : MID;
                2'b01:   w_data = r_phase;
                2'b10:   w_data = w_cur_bit ? r_phase : r_phase + MID;
                default: w_data = MID;
            endcase
        end
    end

    assign bus.busy      = (r_state == S_SEND);
    assign bus.done      = r_done;
    assign bus.bit_out   = (r_state == S_SEND) && w_cur_bit;
    assign bus.data_out  = w_data;
    assign bus.dbg_state = (r_state == S_SEND);
endmodule

// File: tb/tb_multi_mode_modulator.sv
// Directed bench for multi_mode_modulator: per-cycle expectations go into a queue, a monitor pops and compares.
// Frame length follows MOD_PARITY_EN so the same vectors cover both builds.
module tb_multi_mode_modulator;
    localparam int MSG_W  = 8;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 9;
    localparam int BAUD_W = 12;
    localparam int W      = 3 + DATA_W;
`ifdef MOD_PARITY_EN
    localparam int N = MSG_W + 1;
`else
    localparam int N = MSG_W;
`endif
    localparam logic [DATA_W-1:0] MID = 8'd128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_mode_modulator_if #(.MSG_W(MSG_W), .DATA_W(DATA_W), .DIV_W(DIV_W), .BAUD_W(BAUD_W)) bus ();

    multi_mode_modulator #(.MSG_W(MSG_W), .DATA_W(DATA_W), .DIV_W(DIV_W), .BAUD_W(BAUD_W)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;
    string        mon_nm;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            mon_act = {bus.busy, bus.done, bus.bit_out, bus.data_out};
            n_vec++;
            if (mon_act !== mon_exp) begin
                n_err++;
                $display("FAIL %s @%0t: busy/done/bit/data got %b/%b/%b/%0d want %b/%b/%b/%0d",
                         mon_nm, $time, mon_act[W-1], mon_act[W-2], mon_act[W-3], mon_act[DATA_W-1:0],
                         mon_exp[W-1], mon_exp[W-2], mon_exp[W-3], mon_exp[DATA_W-1:0]);
            end
        end
    end

    task automatic push_exp(input logic b, input logic d, input logic bo,
                            input logic [DATA_W-1:0] dat, input string nm);
        exp_q.push_back({b, d, bo, dat});
        name_q.push_back(nm);
    endtask

    task automatic check_now(input string nm);
        n_vec++;
        if ({bus.busy, bus.done, bus.bit_out, bus.data_out} !== {1'b0, 1'b0, 1'b0, MID}) begin
            n_err++;
            $display("FAIL %s @%0t: busy/done/bit/data got %b/%b/%b/%0d want 0/0/0/%0d",
                     nm, $time, bus.busy, bus.done, bus.bit_out, bus.data_out, MID);
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: %0d expected cycles still pending after %0d cycles", nm, exp_q.size(), budget);
            exp_q.delete();
            name_q.delete();
        end
    endtask

    function automatic logic frame_bit(input logic [MSG_W-1:0] m, input int idx);
        if (idx < MSG_W) return m[MSG_W-1-idx];
        return ^m;
    endfunction

    task automatic begin_frame(input logic [1:0] md, input logic [MSG_W-1:0] m,
                               input int hi, input int lo, input int bd);
        @(negedge clk);
        bus.mode     = md;
        bus.message  = m;
        bus.div_hi   = DIV_W'(hi);
        bus.div_lo   = DIV_W'(lo);
        bus.baud_div = BAUD_W'(bd);
        bus.send     = 1'b1;
    endtask

    task automatic drop_send();
        @(negedge clk);
        bus.send = 1'b0;
    endtask

    task automatic push_end(input string nm);
        push_exp(1'b0, 1'b1, 1'b0, MID, nm);
        push_exp(1'b0, 1'b0, 1'b0, MID, nm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic                b;
        logic [DATA_W-1:0]   d;
        bus.send = 1'b0; bus.mode = 2'b00; bus.message = '0;
        bus.div_hi = '0; bus.div_lo = '0; bus.baud_div = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.send     = 1'($urandom_range(0, 1));
            bus.mode     = 2'($urandom_range(0, 3));
            bus.message  = MSG_W'($urandom_range(0, 255));
            bus.div_hi   = DIV_W'($urandom_range(0, 511));
            bus.div_lo   = DIV_W'($urandom_range(0, 511));
            bus.baud_div = BAUD_W'($urandom_range(0, 4095));
            #1 check_now("rst_hold");
        end
        bus.send = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(1'b0, 1'b0, 1'b0, MID, "idle");
        push_exp(1'b0, 1'b0, 1'b0, MID, "idle");
        wait_drain(10, "idle");

        // ASK: A0, div 0, baud 15.
        begin_frame(2'b00, 8'hA0, 0, 0, 15);
        for (int c = 1; c <= N * 16; c++) begin
            b = frame_bit(8'hA0, (c - 1) / 16);
            d = b ? DATA_W'(c - 1) : MID;
            push_exp(1'b1, 1'b0, b, d, "ask");
        end
        push_end("ask_end");
        drop_send();
        wait_drain(400, "ask");

        // FSK: F0, mark every 2 cycles, space every 4, continuous phase.
        begin_frame(2'b01, 8'hF0, 1, 3, 7);
        for (int c = 1; c <= N * 8; c++) begin
            b = frame_bit(8'hF0, (c - 1) / 8);
            d = (c <= 32) ? DATA_W'((c - 1) / 2) : DATA_W'(16 + (c - 33) / 4);
            push_exp(1'b1, 1'b0, b, d, "fsk");
        end
        push_end("fsk_end");
        drop_send();
        wait_drain(200, "fsk");

        // BPSK: 80, zero bits shifted by half a period.
        begin_frame(2'b10, 8'h80, 0, 0, 3);
        for (int c = 1; c <= N * 4; c++) begin
            b = frame_bit(8'h80, (c - 1) / 4);
            d = b ? DATA_W'(c - 1) : DATA_W'(c - 1 + 128);
            push_exp(1'b1, 1'b0, b, d, "bpsk");
        end
        push_end("bpsk_end");
        drop_send();
        wait_drain(200, "bpsk");

        // Reserved mode: samples stay at midscale, timing unchanged.
        begin_frame(2'b11, 8'h5A, 0, 0, 1);
        for (int c = 1; c <= N * 2; c++) begin
            b = frame_bit(8'h5A, (c - 1) / 2);
            push_exp(1'b1, 1'b0, b, MID, "rsvd");
        end
        push_end("rsvd_end");
        drop_send();
        wait_drain(100, "rsvd");

        // Parity-sensitive frame: 07 at one cycle per bit.
        begin_frame(2'b00, 8'h07, 0, 0, 0);
        for (int c = 1; c <= N; c++) begin
            b = frame_bit(8'h07, c - 1);
            d = b ? DATA_W'(c - 1) : MID;
            push_exp(1'b1, 1'b0, b, d, "len");
        end
        push_end("len_end");
        drop_send();
        wait_drain(50, "len");

        // Back-to-back: send held, message changed mid-frame only lands in frame 2.
        begin_frame(2'b00, 8'hC3, 0, 0, 0);
        for (int c = 1; c <= N; c++) begin
            b = frame_bit(8'hC3, c - 1);
            d = b ? DATA_W'(c - 1) : MID;
            push_exp(1'b1, 1'b0, b, d, "b2b_f1");
        end
        push_exp(1'b0, 1'b1, 1'b0, MID, "b2b_done1");
        for (int k = 1; k <= N; k++) begin
            b = frame_bit(8'h3C, k - 1);
            d = b ? DATA_W'(k - 1) : MID;
            push_exp(1'b1, 1'b0, b, d, "b2b_f2");
        end
        push_end("b2b_end");
        repeat (3) @(negedge clk);
        bus.message = 8'h3C;
        repeat (9) @(negedge clk);
        bus.send = 1'b0;
        wait_drain(60, "b2b");

        // Asynchronous reset mid-frame, checked between clock edges.
        begin_frame(2'b00, 8'hFF, 0, 0, 15);
        for (int c = 1; c <= 5; c++) push_exp(1'b1, 1'b0, 1'b1, DATA_W'(c - 1), "pre_rst");
        drop_send();
        wait_drain(20, "pre_rst");
        #1 rst_n = 1'b0;
        #1 check_now("rst_mid");
        @(negedge clk);
        check_now("rst_mid_hold");
        rst_n = 1'b1;
        push_exp(1'b0, 1'b0, 1'b0, MID, "post_rst");
        push_exp(1'b0, 1'b0, 1'b0, MID, "post_rst");
        wait_drain(10, "post_rst");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multi_mode_modulator.md
Name: multi_mode_modulator

Overview:
- Parametrised serial-message modulator with ASK, FSK and BPSK modes and a free-running sawtooth carrier generator.
- Baud rate and mark/space carrier dividers are runtime inputs; the baud rate is decoupled from the carrier.
- Adds a send/busy/done handshake so a host FSM can stream messages back to back.
- Sits between the message source and the DAC sample bus.

Parameters:
- MSG_W, 8, message bits per frame, sent MSB first.
- DATA_W, 8, sample width; midscale MID = 2^(DATA_W-1).
- DIV_W, 9, width of the carrier divider inputs.
- BAUD_W, 12, width of the baud divider input.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- send  in  1  start request; sampled in IDLE only.
- mode  in  2  00 ASK, 01 FSK, 10 BPSK, 11 reserved (outputs MID).
- message  in  MSG_W  frame payload.
- div_hi  in  DIV_W  carrier divider for bit=1 (and for all bits in ASK and BPSK).
- div_lo  in  DIV_W  carrier divider for bit=0 in FSK.
- baud_div  in  BAUD_W  bit period = baud_div+1 clk cycles.
- busy  out  1  high while a frame is transmitting.
- done  out  1  one-cycle pulse at end of frame.
- bit_out  out  1  current transmitted bit; 0 when idle.
- data_out  out  DATA_W  modulated sample.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - busy=0, done=0, bit_out=0, data_out=MID.
  - Internal phase=0, counters=0, FSM=IDLE.
  - Applies at any point, including mid-frame.
- FSM states are IDLE and SEND.
- IDLE:
  - data_out=MID; phase, carrier counter and baud counter are held at 0.
  - When send=1 at edge E0: latch message, mode, div_hi, div_lo and baud_div into a shadow; go to SEND.
  - From the cycle after E0: busy=1, bit_out=message[MSG_W-1].
- SEND:
  - The baud counter counts 0..baud_div.
  - At wrap, the shift register advances to the next bit and the carrier counter clears to 0.
  - After N = MSG_W bits (N × (baud_div+1) cycles), return to IDLE. In the first IDLE cycle: busy=0, done=1, bit_out=0.
  - send=1 during SEND is ignored; shadow inputs are never re-sampled mid-frame.
  - send=1 in the done cycle is accepted, since the FSM is in IDLE.
- Carrier:
  - The carrier counter counts 0..div; a tick occurs at count==div.
  - phase (DATA_W bits) increments on each tick and wraps modulo 2^DATA_W.
  - div=0 gives one tick per clk.
  - phase is continuous across bit boundaries (continuous-phase FSK); only the divider count resets.
- Active divider: div_hi, except FSK with bit=0, which uses div_lo.
- data_out in SEND:
  - ASK: phase if bit=1, else MID. phase keeps advancing while MID is output.
  - FSK: phase.
  - BPSK: phase if bit=1; phase+MID (mod 2^DATA_W, a half-period shift) if bit=0.
  - Reserved mode: MID for the whole frame. busy/done timing is unchanged.
- Registered outputs: data_out reflects the phase register value of the current cycle. The first SEND cycle shows phase 0 (ASK/FSK with bit=1).

Optional Feature:
- Macro: MOD_PARITY_EN.
- Defined: one even-parity bit (XOR of the latched message) is appended after the LSB. Frame length N = MSG_W+1 bits; busy is extended accordingly.
- Undefined: N = MSG_W, with no parity logic.

Test Plan:
- Reset: hold rst=0 with random inputs -> data_out=128, busy=0, done=0, bit_out=0. Pull rst=0 mid-frame -> same values immediately, with no clk edge.
- ASK: message=8'hA0, div_hi=0, baud_div=15, pulse send. Required response:
  - Cycles 1-16: data_out=0..15.
  - Cycles 17-32: data_out=128.
  - Cycles 33-48: data_out=32..47.
  - Cycles 49-128: data_out=128 (bits 4..0 are 0; phase keeps advancing hidden).
  - busy is high for exactly 128 cycles; done is high at cycle 129.
- FSK: message=8'hF0, div_hi=1, div_lo=3, baud_div=7:
  - Bits 7..4: phase advances once per 2 cycles.
  - Bits 3..0: phase advances once per 4 cycles.
  - No phase jump at the 1->0 boundary (value continues from the last bit-1 phase).
- BPSK: message=8'h80, div_hi=0, baud_div=3 -> data_out=0,1,2,3, then 132,133,134,135 for bit 6.
- Handshake: send held high for the whole frame -> the second frame starts in the done cycle (busy high again the cycle after done). Changing message mid-frame has no effect on bit_out.
- MOD_PARITY_EN: message=8'h07, baud_div=0 -> bit_out=0,0,0,0,0,1,1,1,1, busy for 9 cycles, done at cycle 10. Without the macro: busy for 8 cycles.
